// File: rtl/ps2_rx_ctrl.sv
// ps2_rx_ctrl: PS/2 receive path -- pad synchronizers, frame FSM, E0/F0 prefix strip, FWFT event FIFO.
// Define PS2_RX_TYPEMATIC_FILTER_EN to suppress repeated make codes from key auto-repeat.
module ps2_rx_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                          FPGAClk,
  input  logic                          rst,
  input  logic                          PS2Clk,
  input  logic                          datain,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_break,
  output logic                          ev_ext,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   fe_s, bit_s;
  state_t                 state_q, state_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   byte_done_q, byte_done_d;
  logic                   frame_err_q, frame_err_d;
  logic                   ext_flag_q, ext_flag_d, brk_flag_q, brk_flag_d;
  logic                   cand_s, push_s, pop_s, full_s, wr_s;
  logic [9:0]             mem_q [FIFO_DEPTH];
  logic [9:0]             mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   overflow_q, overflow_d;

  assign clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], PS2Clk};
  assign data_sync_d = {data_sync_q[SYNC_STAGES-2:0], datain};
  assign clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
  assign fe_s        = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign bit_s       = data_sync_q[SYNC_STAGES-1];

  // Frame sequencer and inactivity timeout; a falling edge always wins over a timeout.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    byte_done_d = 1'b0;
    frame_err_d = 1'b0;
    tmo_d       = (fe_s || state_q == IDLE) ? '0 : tmo_q + TW'(1);
    if (fe_s) begin
      case (state_q)
        IDLE: begin
          if (!bit_s) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d  = {bit_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          state_d  = (bitcnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = bit_s;
          state_d = STOP;
        end
        STOP: begin
          if ((^{shift_q, par_q}) && bit_s) begin
            byte_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
      frame_err_d = 1'b1;
      state_d     = IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // Prefix bytes only set flags; any error forgets a half-seen prefix.
  always_comb begin
    ext_flag_d = ext_flag_q;
    brk_flag_d = brk_flag_q;
    cand_s     = 1'b0;
    if (frame_err_d) begin
      ext_flag_d = 1'b0;
      brk_flag_d = 1'b0;
    end else if (byte_done_q) begin
      if (shift_q == 8'hE0) begin
        ext_flag_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_flag_d = 1'b1;
      end else begin
        cand_s     = 1'b1;
        ext_flag_d = 1'b0;
        brk_flag_d = 1'b0;
      end
    end else begin
      cand_s = 1'b0;
    end
  end

`ifdef PS2_RX_TYPEMATIC_FILTER_EN
  logic       lm_valid_q, lm_valid_d, lm_ext_q, lm_ext_d;
  logic [7:0] lm_code_q, lm_code_d;
  logic       repeat_s;

  assign repeat_s = lm_valid_q && (lm_ext_q == ext_flag_q) && (lm_code_q == shift_q);

  // Drop auto-repeated makes; a matching break re-arms the next make.
  always_comb begin
    lm_valid_d = lm_valid_q;
    lm_ext_d   = lm_ext_q;
    lm_code_d  = lm_code_q;
    push_s     = cand_s;
    if (cand_s && !brk_flag_q) begin
      if (repeat_s) begin
        push_s = 1'b0;
      end else begin
        lm_valid_d = 1'b1;
        lm_ext_d   = ext_flag_q;
        lm_code_d  = shift_q;
      end
    end else if (cand_s && repeat_s) begin
      lm_valid_d = 1'b0;
    end else begin
      push_s = cand_s;
    end
  end

  // Last-make register.
  always_ff @(posedge FPGAClk or negedge rst) begin
    if (!rst) begin
      lm_valid_q <= 1'b0;
      lm_ext_q   <= 1'b0;
      lm_code_q  <= 8'h00;
    end else begin
      lm_valid_q <= lm_valid_d;
      lm_ext_q   <= lm_ext_d;
      lm_code_q  <= lm_code_d;
    end
  end
`else
  assign push_s = cand_s;
`endif

  assign pop_s  = (count_q != '0) && ev_ready;
  assign full_s = (count_q == CNT_FULL);
  assign wr_s   = push_s && (!full_s || pop_s);

  // FIFO bookkeeping: a push into a full FIFO survives only if the head leaves in the same cycle.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q + AW'(wr_s);
    rd_ptr_d   = rd_ptr_q + AW'(pop_s);
    overflow_d = overflow_q | (push_s & full_s & ~pop_s);
    if (wr_s) begin
      mem_d[wr_ptr_q] = {ext_flag_q, brk_flag_q, shift_q};
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; synchronizers idle high.
  always_ff @(posedge FPGAClk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      ext_flag_q  <= 1'b0;
      brk_flag_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 10'h000;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      byte_done_q <= byte_done_d;
      frame_err_q <= frame_err_d;
      ext_flag_q  <= ext_flag_d;
      brk_flag_q  <= brk_flag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      mem_q       <= mem_d;
    end
  end

  assign ev_valid                      = (count_q != '0);
  assign {ev_ext, ev_break, ev_code}   = mem_q[rd_ptr_q];
  assign frame_err                     = frame_err_q;
  assign overflow                      = overflow_q;
  assign fifo_count                    = count_q;

endmodule
